pixel_fetch: RTL and testbench

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/video_pkg.sv | 46 ++++
 rtl/fb_bram.sv | 28 ++
 rtl/pixel_fetch.sv | 158 +++++++++++++++
 tb/tb_pixel_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants, pixel type and swap FSM encoding for the
// pixel fetch path.
package video_pkg;

  localparam int unsigned H_ACTIVE            = 1280;
  localparam int unsigned V_ACTIVE            = 720;
  localparam int unsigned FB_W_DEFAULT        = 320;
  localparam int unsigned FB_H_DEFAULT        = 180;
  localparam int unsigned SCALE_SHIFT_DEFAULT = 2;
  localparam int unsigned FB_ADDR_W           = 17;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // RGB332 to RGB888 by bit replication so full-scale codes map to 8'hFF.
  function automatic rgb_t rgb332_expand(input logic [7:0] d);
    rgb_t c;
    c.r = {d[7:5], d[7:5], d[7:6]};
    c.g = {d[4:2], d[4:2], d[4:3]};
    c.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
    return c;
  endfunction

  // Multiply by a constant as a sum of shifted copies. With k fixed at
  // elaboration this reduces to a few adders (320 = 256 + 64).
  function automatic logic [FB_ADDR_W-1:0] mul_const(
    input logic [FB_ADDR_W-1:0] v,
    input int unsigned          k
  );
    logic [FB_ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FB_ADDR_W; i++) begin
      if (k[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_bram.sv
// Simple dual-port frame-buffer RAM: one write port, one read port with
// a registered read. No reset so the array maps onto block RAM.
module fb_bram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 115200
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, one cycle latency.
  always_ff @(posedge clk_in) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_fetch.sv
// Double-buffered scaled frame-buffer fetch with swap-on-new-frame.
// Build option: define PIXEL_FETCH_PALETTE_EN to treat stored bytes as
// indices into a 256x24 palette; otherwise bytes are RGB332.
//
// Swap FSM:
//   state        | meaning
//   SWAP_IDLE    | writes accepted into the back bank, waiting for swap_req_in
//   SWAP_PENDING | writes stalled, swap happens on the next nf_in
module pixel_fetch
  import video_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEFAULT,
  parameter int unsigned FB_W        = FB_W_DEFAULT,
  parameter int unsigned FB_H        = FB_H_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        nf_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  input  logic        wr_valid_in,
  output logic        wr_ready_out,
  input  logic [8:0]  wr_x_in,
  input  logic [7:0]  wr_y_in,
  input  logic [7:0]  wr_data_in,
  input  logic        swap_req_in,
  output logic        swap_ack_out,
  input  logic        pal_we_in,
  input  logic [7:0]  pal_addr_in,
  input  logic [23:0] pal_data_in
);

  localparam int unsigned BANK_SIZE = FB_W * FB_H;
  localparam int unsigned DEPTH     = 2 * BANK_SIZE;
  localparam int unsigned H_LIM     = FB_W << SCALE_SHIFT;
  localparam int unsigned V_LIM     = FB_H << SCALE_SHIFT;
  localparam logic [FB_ADDR_W-1:0] BANK_BASE = FB_ADDR_W'(BANK_SIZE);

  swap_state_t state_q, state_d;
  logic        front_bank_q;
  logic        swap_fire;
  logic        swap_ack_q;

  logic                 active_rd;
  logic                 active_d1_q;
  logic [FB_ADDR_W-1:0] rd_x, rd_y, rd_addr;
  logic [7:0]           rd_data;

  logic                 wr_accept, wr_in_range, wr_en;
  logic [FB_ADDR_W-1:0] wr_addr;

  rgb_t pix_rgb;
  rgb_t rgb_q;

  // Swap FSM next state; swap_fire marks the cycle the front bank flips.
  always_comb begin
    state_d   = state_q;
    swap_fire = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req_in) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (nf_in) begin
          state_d   = SWAP_IDLE;
          swap_fire = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Swap FSM state, front bank select and registered ack pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= SWAP_IDLE;
      front_bank_q <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_q ^ swap_fire;
      swap_ack_q   <= swap_fire;
    end
  end

  assign wr_ready_out = (state_q == SWAP_IDLE);
  assign swap_ack_out = swap_ack_q;

  // Read address from the scaled timing counters; parked at 0 when blanked.
  always_comb begin
    rd_x      = FB_ADDR_W'(hcount_in >> SCALE_SHIFT);
    rd_y      = FB_ADDR_W'(vcount_in >> SCALE_SHIFT);
    active_rd = (32'(hcount_in) < H_LIM) && (32'(vcount_in) < V_LIM);
    rd_addr   = '0;
    if (active_rd) begin
      rd_addr = (front_bank_q ? BANK_BASE : '0) + mul_const(rd_y, FB_W) + rd_x;
    end
  end

  // Write address into the back bank; out-of-range coordinates are
  // consumed but never reach the RAM.
  always_comb begin
    wr_accept   = wr_valid_in && wr_ready_out;
    wr_in_range = (32'(wr_x_in) < FB_W) && (32'(wr_y_in) < FB_H);
    wr_en       = wr_accept && wr_in_range;
    wr_addr     = (front_bank_q ? '0 : BANK_BASE)
                + mul_const(FB_ADDR_W'(wr_y_in), FB_W)
                + FB_ADDR_W'(wr_x_in);
  end

  fb_bram #(
    .DATA_W (8),
    .ADDR_W (FB_ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fb_bram (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef PIXEL_FETCH_PALETTE_EN
  logic [23:0] palette [256];

  // Palette register file; contents are not reset.
  always_ff @(posedge clk_in) begin
    if (pal_we_in) palette[pal_addr_in] <= pal_data_in;
  end

  assign pix_rgb = rgb_t'(palette[rd_data]);
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we_in, pal_addr_in, pal_data_in};

  assign pix_rgb = rgb332_expand(rd_data);
`endif

  // Second pipeline stage: colour lookup, blanked by the delayed active flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_d1_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      active_d1_q <= active_rd;
      rgb_q       <= active_d1_q ? pix_rgb : '0;
    end
  end

  assign red_out   = rgb_q.r;
  assign green_out = rgb_q.g;
  assign blue_out  = rgb_q.b;

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: reset, write/swap handshake, 2-cycle
// read latency, blanking and out-of-range write discard.
module tb_pixel_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        nf_in;
  logic [7:0]  red_out, green_out, blue_out;
  logic        wr_valid_in;
  logic        wr_ready_out;
  logic [8:0]  wr_x_in;
  logic [7:0]  wr_y_in;
  logic [7:0]  wr_data_in;
  logic        swap_req_in;
  logic        swap_ack_out;
  logic        pal_we_in;
  logic [7:0]  pal_addr_in;
  logic [23:0] pal_data_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected colours for the stored bytes used below.
`ifdef PIXEL_FETCH_PALETTE_EN
  localparam logic [23:0] C_2A = 24'h123456;
`else
  localparam logic [23:0] C_2A = 24'h2449AA;
`endif
  localparam logic [23:0] C_E0 = 24'hFF0000;
  localparam logic [23:0] C_1C = 24'h00FF00;

  pixel_fetch dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .nf_in        (nf_in),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .wr_valid_in  (wr_valid_in),
    .wr_ready_out (wr_ready_out),
    .wr_x_in      (wr_x_in),
    .wr_y_in      (wr_y_in),
    .wr_data_in   (wr_data_in),
    .swap_req_in  (swap_req_in),
    .swap_ack_out (swap_ack_out),
    .pal_we_in    (pal_we_in),
    .pal_addr_in  (pal_addr_in),
    .pal_data_in  (pal_data_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'h00, red_out, green_out, blue_out};
  endfunction

  task automatic write_px(input int x, input int y, input logic [7:0] d);
    wr_valid_in = 1'b1;
    wr_x_in     = 9'(x);
    wr_y_in     = 8'(y);
    wr_data_in  = d;
    check("wr_ready", 32'(wr_ready_out), 32'd1);
    tick();
    wr_valid_in = 1'b0;
  endtask

  task automatic read_px(input int h, input int v, input logic [23:0] exp, input string tag);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    tick();
    tick();
    check(tag, rgb_now(), {8'h00, exp});
  endtask

`ifdef PIXEL_FETCH_PALETTE_EN
  task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
    pal_we_in   = 1'b1;
    pal_addr_in = a;
    pal_data_in = d;
    tick();
    pal_we_in = 1'b0;
  endtask
`endif

  initial begin
    rst_in      = 1'b1;
    hcount_in   = 11'd2000;
    vcount_in   = 10'd1000;
    nf_in       = 1'b0;
    wr_valid_in = 1'b0;
    wr_x_in     = '0;
    wr_y_in     = '0;
    wr_data_in  = '0;
    swap_req_in = 1'b0;
    pal_we_in   = 1'b0;
    pal_addr_in = '0;
    pal_data_in = '0;

    tick();
    tick();
    check("rst_rgb", rgb_now(), 32'd0);
    check("rst_ack", 32'(swap_ack_out), 32'd0);
    check("rst_ready", 32'(wr_ready_out), 32'd1);
    rst_in = 1'b0;

`ifdef PIXEL_FETCH_PALETTE_EN
    pal_write(8'h2A, 24'h123456);
    pal_write(8'hE0, 24'hFF0000);
    pal_write(8'h1C, 24'h00FF00);
`endif

    // Fill the back bank (bank 1) and try an out-of-range x.
    write_px(5, 3, 8'h2A);
    write_px(0, 0, 8'hE0);
    write_px(0, 1, 8'h1C);
    write_px(320, 0, 8'h03);

    // Swap request, ~50 cycles pending, then the new-frame pulse.
    swap_req_in = 1'b1;
    tick();
    swap_req_in = 1'b0;
    check("pend_ready", 32'(wr_ready_out), 32'd0);
    check("pend_ack", 32'(swap_ack_out), 32'd0);
    repeat (24) tick();
    swap_req_in = 1'b1;
    tick();
    swap_req_in = 1'b0;
    repeat (24) tick();
    check("pend_ready_hold", 32'(wr_ready_out), 32'd0);
    nf_in = 1'b1;
    tick();
    nf_in = 1'b0;
    check("swap_ack", 32'(swap_ack_out), 32'd1);
    check("swap_ready", 32'(wr_ready_out), 32'd1);
    tick();
    check("swap_ack_1cyc", 32'(swap_ack_out), 32'd0);
    check("swap_ready_stay", 32'(wr_ready_out), 32'd1);

    // Stream hcount 20..23 on row 12: pixel (5,3) for four cycles, 2-cycle latency.
    for (int i = 0; i < 6; i++) begin
      hcount_in = (i < 4) ? 11'(20 + i) : 11'd2000;
      vcount_in = 10'd12;
      tick();
      check($sformatf("stream_%0d", i), rgb_now(),
            {8'h00, ((i >= 1 && i <= 4) ? C_2A : 24'h000000)});
    end

    read_px(0, 0, C_E0, "rgb_e0");
    read_px(0, 4, C_1C, "oob_x_no_write");
    read_px(1280, 100, 24'h000000, "blank_h");
    read_px(3, 2, C_E0, "scaled_0_0");
    read_px(0, 720, 24'h000000, "blank_v");

`ifdef PIXEL_FETCH_PALETTE_EN
    pal_write(8'h1C, 24'h0A0B0C);
    read_px(2, 5, 24'h0A0B0C, "pal_update");
`endif

    // Back bank is now 0: y=180 must not alias onto bank 1 pixel (0,0).
    write_px(0, 180, 8'h03);
    write_px(5, 3, 8'hE0);
    read_px(20, 12, C_2A, "front_untouched");
    read_px(0, 0, C_E0, "oob_y_no_write");

    // Request and nf together in IDLE: only enters PENDING.
    swap_req_in = 1'b1;
    nf_in       = 1'b1;
    tick();
    swap_req_in = 1'b0;
    nf_in       = 1'b0;
    check("same_cyc_ack", 32'(swap_ack_out), 32'd0);
    check("same_cyc_ready", 32'(wr_ready_out), 32'd0);
    repeat (3) tick();
    nf_in = 1'b1;
    tick();
    nf_in = 1'b0;
    check("next_nf_ack", 32'(swap_ack_out), 32'd1);
    read_px(21, 13, C_E0, "bank0_front");

    // Reset while PENDING drops the swap.
    swap_req_in = 1'b1;
    tick();
    swap_req_in = 1'b0;
    check("pend2_ready", 32'(wr_ready_out), 32'd0);
    rst_in = 1'b1;
    nf_in  = 1'b1;
    tick();
    check("rst_pend_ack", 32'(swap_ack_out), 32'd0);
    check("rst_pend_ready", 32'(wr_ready_out), 32'd1);
    check("rst_pend_rgb", rgb_now(), 32'd0);
    rst_in = 1'b0;
    nf_in  = 1'b0;
    tick();
    nf_in = 1'b1;
    tick();
    nf_in = 1'b0;
    check("rst_drop_swap", 32'(swap_ack_out), 32'd0);
    read_px(20, 12, C_E0, "rst_front0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
